seq_multiplier: RTL

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: 32x32 signed shift-add multiplier, one iteration per clock,
// fixed 32-cycle latency, low 32 bits of the product plus an overflow flag.
module seq_multiplier (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_MULT,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   localparam int unsigned W  = 32;
   localparam int unsigned PW = 64;
   localparam int unsigned CW = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] mcand_q, mcand_d;
   logic [PW-1:0] acc_q, acc_d;
   logic [W-1:0]  mplier_q, mplier_d;
   logic          neg_q, neg_d;
   logic [W-1:0]  result_q, result_d;
   logic          exc_q, exc_d;
   logic          rdy_q, rdy_d;
   logic          busy_q, busy_d;

   logic [W-1:0]  mag_a_c, mag_b_c;
   logic [PW-1:0] sum_c, prod_c;
   logic          ovf_c;

   // Operand magnitudes; -2^31 maps onto the unsigned magnitude 2^31.
   always_comb begin
      mag_a_c = data_operandA[W-1] ? W'(-data_operandA) : data_operandA;
      mag_b_c = data_operandB[W-1] ? W'(-data_operandB) : data_operandB;
   end

   // Accumulate the current partial product and apply the sign to the final sum.
   always_comb begin
      sum_c  = acc_q + (mplier_q[0] ? mcand_q : '0);
      prod_c = (neg_q && (sum_c != '0)) ? PW'(-sum_c) : sum_c;
      ovf_c  = (prod_c[PW-1:W-1] != {(PW-W+1){prod_c[W-1]}});
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      result_d = result_q;
      exc_d    = exc_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (ctrl_MULT) begin
               state_d  = RUN;
               cnt_d    = '0;
               mcand_d  = PW'(mag_a_c);
               mplier_d = mag_b_c;
               acc_d    = '0;
               neg_d    = data_operandA[W-1] ^ data_operandB[W-1];
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            acc_d    = sum_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            if (cnt_q == CW'(W-1)) begin
               state_d  = DONE;
               result_d = prod_c[W-1:0];
               exc_d    = ovf_c;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == RUN);
      rdy_d  = (state_d == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
         rdy_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         rdy_q    <= rdy_d;
         busy_q   <= busy_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule
